alu_param: RTL and testbench

- Parametrised successor to the microcontroller 8-bit ALU.
- Datapath width is generic, and operations use an explicit valid/ready handshake.
- Adds shift, compare and multi-cycle multiply operations, plus a registered output strobe.
- Sits between the instruction decoder and the internal data bus. The decoder holds an opcode until it is accepted; the ALU drives results back on OutData.

---
 rtl/alu_param.sv | 203 ++++++++++++++++++++
 tb/tb_alu_param.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_param.sv
// Parametrised ALU with a valid/ready opcode handshake, registered output strobe
// and an optional shift-add multiplier that takes WIDTH cycles.
module alu_param #(
  parameter int WIDTH  = 8,
  parameter int MUL_EN = 1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [3:0]       Op,
  input  logic             Op_Valid,
  output logic             Op_Ready,
  input  logic [WIDTH-1:0] InData,
  output logic [WIDTH-1:0] OutData,
  output logic             Out_Valid,
  output logic [WIDTH-1:0] Index_Reg,
  output logic             FlagZ,
  output logic             FlagC,
  output logic             FlagN,
  output logic             FlagE,
  output logic             Busy
);

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,  OP_LDA  = 4'd1,  OP_LDB  = 4'd2,  OP_LDACC = 4'd3,
    OP_LDID  = 4'd4,  OP_ADD  = 4'd5,  OP_SUB  = 4'd6,  OP_AND   = 4'd7,
    OP_OR    = 4'd8,  OP_XOR  = 4'd9,  OP_SHL  = 4'd10, OP_SHR   = 4'd11,
    OP_CMPE  = 4'd12, OP_MUL  = 4'd13, OP_OEACC = 4'd14, OP_OEID = 4'd15
  } op_e;

  typedef enum logic {S_IDLE, S_MUL} state_e;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, index_q, index_d;
  logic [WIDTH-1:0] outData_q, outData_d;
  logic outValid_q, outValid_d;
  logic flagZ_q, flagZ_d, flagC_q, flagC_d, flagN_q, flagN_d, flagE_q, flagE_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d, prod_q, prod_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [WIDTH:0] sum;
  logic [2*WIDTH-1:0] addend, prodNext;
  logic updZn;

  assign sum      = {1'b0, a_q} + {1'b0, b_q};
  assign addend   = mplier_q[0] ? mcand_q : '0;
  assign prodNext = prod_q + addend;

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    index_d    = index_q;
    outData_d  = outData_q;
    outValid_d = 1'b0;
    flagZ_d    = flagZ_q;
    flagC_d    = flagC_q;
    flagN_d    = flagN_q;
    flagE_d    = flagE_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    prod_d     = prod_q;
    cnt_d      = cnt_q;
    updZn      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (Op_Valid) begin
          case (op_e'(Op))
            OP_LDA:   a_d = InData;
            OP_LDB:   b_d = InData;
            OP_LDACC: acc_d = InData;
            OP_LDID:  index_d = InData;
            OP_ADD: begin
              acc_d   = sum[WIDTH-1:0];
              flagC_d = sum[WIDTH];
              updZn   = 1'b1;
            end
            OP_SUB: begin
              acc_d   = a_q - b_q;
              flagC_d = (a_q < b_q);
              updZn   = 1'b1;
            end
            OP_AND: begin
              acc_d   = a_q & b_q;
              flagC_d = 1'b0;
              updZn   = 1'b1;
            end
            OP_OR: begin
              acc_d   = a_q | b_q;
              flagC_d = 1'b0;
              updZn   = 1'b1;
            end
            OP_XOR: begin
              acc_d   = a_q ^ b_q;
              flagC_d = 1'b0;
              updZn   = 1'b1;
            end
            OP_SHL: begin
              acc_d   = {acc_q[WIDTH-2:0], 1'b0};
              flagC_d = acc_q[WIDTH-1];
              updZn   = 1'b1;
            end
            OP_SHR: begin
              acc_d   = {1'b0, acc_q[WIDTH-1:1]};
              flagC_d = acc_q[0];
              updZn   = 1'b1;
            end
            OP_CMPE: flagE_d = (a_q == b_q);
            // With the multiplier disabled this opcode falls through as a NOP
            OP_MUL: begin
              if (MUL_EN != 0) begin
                mcand_d  = {{WIDTH{1'b0}}, a_q};
                mplier_d = b_q;
                prod_d   = '0;
                cnt_d    = '0;
                state_d  = S_MUL;
              end
            end
            OP_OEACC: begin
              outData_d  = acc_q;
              outValid_d = 1'b1;
            end
            OP_OEID: begin
              outData_d  = index_q;
              outValid_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      S_MUL: begin
        prod_d   = prodNext;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          acc_d   = prodNext[WIDTH-1:0];
          flagC_d = |prodNext[2*WIDTH-1:WIDTH];
          updZn   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (updZn) begin
      flagZ_d = (acc_d == '0);
      flagN_d = acc_d[WIDTH-1];
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      index_q    <= '0;
      outData_q  <= '0;
      outValid_q <= 1'b0;
      flagZ_q    <= 1'b0;
      flagC_q    <= 1'b0;
      flagN_q    <= 1'b0;
      flagE_q    <= 1'b0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      prod_q     <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      index_q    <= index_d;
      outData_q  <= outData_d;
      outValid_q <= outValid_d;
      flagZ_q    <= flagZ_d;
      flagC_q    <= flagC_d;
      flagN_q    <= flagN_d;
      flagE_q    <= flagE_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      prod_q     <= prod_d;
      cnt_q      <= cnt_d;
    end
  end

  assign Op_Ready  = (state_q == S_IDLE);
  assign Busy      = (state_q != S_IDLE);
  assign OutData   = outData_q;
  assign Out_Valid = outValid_q;
  assign Index_Reg = index_q;
  assign FlagZ     = flagZ_q;
  assign FlagC     = flagC_q;
  assign FlagN     = flagN_q;
  assign FlagE     = flagE_q;

endmodule

// File: tb/tb_alu_param.sv
// Self-checking bench for alu_param: an 8-bit instance with the multiplier and a
// 16-bit instance without it, directed scenarios plus random ops against a model.
module tb_alu_param;

  logic Clk = 1'b0;
  logic Rst;
  logic [3:0] op8, op16;
  logic valid8, valid16;
  logic [7:0] in8;
  logic [15:0] in16;
  logic ready8, ov8, z8, c8, n8, e8, busy8;
  logic ready16, ov16, z16, c16, n16, e16, busy16;
  logic [7:0] out8, idx8;
  logic [15:0] out16, idx16;

  int checks = 0;
  int failures = 0;
  bit tbSel = 1'b0;

  logic [31:0] oOut, oIdx;
  logic oReady, oOv, oBusy;
  logic [3:0] oFlags;

  longint unsigned mA, mB, mAcc, mIdx, mOut, mMask;
  bit mZ, mC, mN, mE, mMulEn;
  int mW;

  always #5 Clk = ~Clk;

  alu_param #(.WIDTH(8), .MUL_EN(1)) dut8 (
    .Clk(Clk), .Rst(Rst), .Op(op8), .Op_Valid(valid8), .Op_Ready(ready8),
    .InData(in8), .OutData(out8), .Out_Valid(ov8), .Index_Reg(idx8),
    .FlagZ(z8), .FlagC(c8), .FlagN(n8), .FlagE(e8), .Busy(busy8)
  );

  alu_param #(.WIDTH(16), .MUL_EN(0)) dut16 (
    .Clk(Clk), .Rst(Rst), .Op(op16), .Op_Valid(valid16), .Op_Ready(ready16),
    .InData(in16), .OutData(out16), .Out_Valid(ov16), .Index_Reg(idx16),
    .FlagZ(z16), .FlagC(c16), .FlagN(n16), .FlagE(e16), .Busy(busy16)
  );

  // Observation mux so scenario tasks can target either instance
  always_comb begin
    oOut = {24'b0, out8};
    oIdx = {24'b0, idx8};
    oReady = ready8;
    oOv = ov8;
    oBusy = busy8;
    oFlags = {z8, c8, n8, e8};
    if (tbSel) begin
      oOut = {16'b0, out16};
      oIdx = {16'b0, idx16};
      oReady = ready16;
      oOv = ov16;
      oBusy = busy16;
      oFlags = {z16, c16, n16, e16};
    end
  end

  task automatic drive(input logic [3:0] op, input logic [31:0] data);
    @(negedge Clk);
    if (tbSel) begin
      op16 = op; in16 = data[15:0]; valid16 = 1'b1;
    end else begin
      op8 = op; in8 = data[7:0]; valid8 = 1'b1;
    end
    @(posedge Clk);
    #1;
    valid8 = 1'b0;
    valid16 = 1'b0;
  endtask

  task automatic waitIdle(output int cyc);
    cyc = 0;
    while (!oReady && cyc < 100) begin
      @(posedge Clk);
      #1;
      cyc++;
    end
  endtask

  task automatic doReset();
    @(negedge Clk);
    Rst = 1'b1;
    valid8 = 1'b0;
    valid16 = 1'b0;
    @(posedge Clk);
    #1;
    Rst = 1'b0;
  endtask

  task automatic modelReset(input int w, input bit mulEn);
    mW = w; mMulEn = mulEn;
    mMask = (64'd1 << w) - 64'd1;
    mA = 0; mB = 0; mAcc = 0; mIdx = 0; mOut = 0;
    mZ = 0; mC = 0; mN = 0; mE = 0;
  endtask

  // Reference behaviour written from the opcode table with plain arithmetic
  task automatic modelApply(input int op, input longint unsigned d);
    longint unsigned r;
    bit zn;
    zn = 1'b0;
    case (op)
      1: mA = d;
      2: mB = d;
      3: mAcc = d;
      4: mIdx = d;
      5: begin r = mA + mB; mC = (r > mMask); mAcc = r & mMask; zn = 1; end
      6: begin mC = (mA < mB); mAcc = (mA - mB) & mMask; zn = 1; end
      7: begin mAcc = mA & mB; mC = 0; zn = 1; end
      8: begin mAcc = mA | mB; mC = 0; zn = 1; end
      9: begin mAcc = mA ^ mB; mC = 0; zn = 1; end
      10: begin mC = ((mAcc >> (mW - 1)) & 1) != 0; mAcc = (mAcc * 2) & mMask; zn = 1; end
      11: begin mC = (mAcc & 1) != 0; mAcc = mAcc / 2; zn = 1; end
      12: mE = (mA == mB);
      13: if (mMulEn) begin
            r = mA * mB; mAcc = r & mMask; mC = ((r >> mW) != 0); zn = 1;
          end
      14: mOut = mAcc;
      15: mOut = mIdx;
      default: ;
    endcase
    if (zn) begin
      mZ = (mAcc == 0);
      mN = ((mAcc >> (mW - 1)) & 1) != 0;
    end
  endtask

  task automatic test_reset();
    tbSel = 1'b0;
    doReset();
    checks++;
    if (oFlags !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b want=0000", oFlags); end
    checks++;
    if (oReady !== 1'b1 || oBusy !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b/%b want=1/0", oReady, oBusy); end
    checks++;
    if (oOut !== 32'h0 || oIdx !== 32'h0 || oOv !== 1'b0) begin
      failures++; $display("FAIL reset_regs out=%h idx=%h ov=%b want 0/0/0", oOut, oIdx, oOv);
    end
  endtask

  task automatic test_add_oe();
    tbSel = 1'b0;
    drive(4'd1, 32'hFF);
    drive(4'd2, 32'h02);
    drive(4'd5, 32'h0);
    drive(4'd14, 32'h0);
    checks++;
    if (oOut !== 32'h01 || oOv !== 1'b1) begin failures++; $display("FAIL add_out got=%h ov=%b want=01 ov=1", oOut, oOv); end
    checks++;
    if (oFlags !== 4'b0100) begin failures++; $display("FAIL add_flags got=%b want=0100", oFlags); end
    @(posedge Clk);
    #1;
    checks++;
    if (oOv !== 1'b0 || oOut !== 32'h01) begin failures++; $display("FAIL add_strobe got ov=%b out=%h want ov=0 out=01", oOv, oOut); end
  endtask

  task automatic test_sub_cmpe();
    tbSel = 1'b0;
    drive(4'd1, 32'h05); drive(4'd2, 32'h06); drive(4'd6, 32'h0);
    checks++;
    if (oFlags !== 4'b0110) begin failures++; $display("FAIL sub_borrow_flags got=%b want=0110", oFlags); end
    drive(4'd14, 32'h0);
    checks++;
    if (oOut !== 32'hFF) begin failures++; $display("FAIL sub_borrow_acc got=%h want=ff", oOut); end
    drive(4'd1, 32'h10); drive(4'd2, 32'h10); drive(4'd6, 32'h0);
    checks++;
    if (oFlags !== 4'b1000) begin failures++; $display("FAIL sub_zero_flags got=%b want=1000", oFlags); end
    drive(4'd12, 32'h0);
    checks++;
    if (oFlags !== 4'b1001) begin failures++; $display("FAIL cmpe_flags got=%b want=1001", oFlags); end
    drive(4'd14, 32'h0);
    checks++;
    if (oOut !== 32'h00) begin failures++; $display("FAIL sub_zero_acc got=%h want=00", oOut); end
  endtask

  task automatic test_mul_stall();
    int cyc;
    tbSel = 1'b0;
    drive(4'd1, 32'h0F); drive(4'd2, 32'h11); drive(4'd12, 32'h0);
    drive(4'd13, 32'h0);
    op8 = 4'd1; in8 = 8'h33; valid8 = 1'b1;
    checks++;
    if (oBusy !== 1'b1 || oReady !== 1'b0) begin failures++; $display("FAIL mul_busy got busy=%b ready=%b want 1/0", oBusy, oReady); end
    waitIdle(cyc);
    checks++;
    if (cyc !== 8) begin failures++; $display("FAIL mul_stall_cycles got=%0d want=8", cyc); end
    @(posedge Clk);
    #1;
    valid8 = 1'b0;
    drive(4'd14, 32'h0);
    checks++;
    if (oOut !== 32'hFF || oFlags !== 4'b0010) begin
      failures++; $display("FAIL mul_result got out=%h flags=%b want ff/0010", oOut, oFlags);
    end
    drive(4'd2, 32'h33); drive(4'd12, 32'h0);
    checks++;
    if (oFlags[0] !== 1'b1) begin failures++; $display("FAIL mul_held_lda got E=%b want=1", oFlags[0]); end
  endtask

  task automatic test_mul_reset();
    int cyc;
    tbSel = 1'b0;
    drive(4'd1, 32'h20); drive(4'd2, 32'h10); drive(4'd13, 32'h0);
    waitIdle(cyc);
    drive(4'd14, 32'h0);
    checks++;
    if (oOut !== 32'h00 || oFlags !== 4'b1101) begin
      failures++; $display("FAIL mul_overflow got out=%h flags=%b want 00/1101", oOut, oFlags);
    end
    drive(4'd3, 32'h5A);
    drive(4'd13, 32'h0);
    @(posedge Clk);
    @(posedge Clk);
    doReset();
    checks++;
    if (oReady !== 1'b1 || oBusy !== 1'b0 || oFlags !== 4'b0000 || oOut !== 32'h0) begin
      failures++; $display("FAIL mul_abort got ready=%b busy=%b flags=%b out=%h want 1/0/0000/0", oReady, oBusy, oFlags, oOut);
    end
    drive(4'd14, 32'h0);
    checks++;
    if (oOut !== 32'h00) begin failures++; $display("FAIL mul_abort_acc got=%h want=00", oOut); end
  endtask

  task automatic test_shift_logic();
    tbSel = 1'b0;
    drive(4'd3, 32'h81); drive(4'd10, 32'h0);
    checks++;
    if (oFlags !== 4'b0100) begin failures++; $display("FAIL shl_flags got=%b want=0100", oFlags); end
    drive(4'd14, 32'h0);
    checks++;
    if (oOut !== 32'h02) begin failures++; $display("FAIL shl_acc got=%h want=02", oOut); end
    drive(4'd11, 32'h0); drive(4'd14, 32'h0);
    checks++;
    if (oOut !== 32'h01 || oFlags !== 4'b0000) begin failures++; $display("FAIL shr got out=%h flags=%b want 01/0000", oOut, oFlags); end
    drive(4'd1, 32'hF0); drive(4'd2, 32'h0F);
    drive(4'd7, 32'h0); drive(4'd14, 32'h0);
    checks++;
    if (oOut !== 32'h00 || oFlags !== 4'b1000) begin failures++; $display("FAIL and got out=%h flags=%b want 00/1000", oOut, oFlags); end
    drive(4'd8, 32'h0); drive(4'd14, 32'h0);
    checks++;
    if (oOut !== 32'hFF || oFlags !== 4'b0010) begin failures++; $display("FAIL or got out=%h flags=%b want ff/0010", oOut, oFlags); end
    drive(4'd9, 32'h0); drive(4'd14, 32'h0);
    checks++;
    if (oOut !== 32'hFF || oFlags !== 4'b0010) begin failures++; $display("FAIL xor got out=%h flags=%b want ff/0010", oOut, oFlags); end
  endtask

  task automatic test_random();
    int op, cyc;
    longint unsigned d;
    tbSel = 1'b0;
    doReset();
    modelReset(8, 1'b1);
    for (int i = 0; i < 120; i++) begin
      op = int'($urandom_range(0, 15));
      d = longint'($urandom) & mMask;
      drive(op[3:0], d[31:0]);
      modelApply(op, d);
      if (op == 13) begin
        waitIdle(cyc);
        checks++;
        if (cyc !== 8) begin failures++; $display("FAIL rand_mul_cycles i=%0d got=%0d want=8", i, cyc); end
      end
      checks++;
      if (oFlags !== {mZ, mC, mN, mE}) begin
        failures++; $display("FAIL rand_flags i=%0d op=%0d got=%b want=%b", i, op, oFlags, {mZ, mC, mN, mE});
      end
      checks++;
      if (oIdx !== mIdx[31:0]) begin failures++; $display("FAIL rand_index i=%0d got=%h want=%h", i, oIdx, mIdx[31:0]); end
      if (op == 14 || op == 15) begin
        checks++;
        if (oOut !== mOut[31:0] || oOv !== 1'b1) begin
          failures++; $display("FAIL rand_oe i=%0d got=%h ov=%b want=%h ov=1", i, oOut, oOv, mOut[31:0]);
        end
      end
      drive(4'd14, 32'h0);
      modelApply(14, 0);
      checks++;
      if (oOut !== mOut[31:0]) begin failures++; $display("FAIL rand_acc i=%0d got=%h want=%h", i, oOut, mOut[31:0]); end
    end
  endtask

  task automatic test_width16();
    tbSel = 1'b1;
    doReset();
    drive(4'd1, 32'hFFFF); drive(4'd2, 32'h0001); drive(4'd5, 32'h0);
    checks++;
    if (oFlags !== 4'b1100) begin failures++; $display("FAIL w16_add_flags got=%b want=1100", oFlags); end
    drive(4'd14, 32'h0);
    checks++;
    if (oOut !== 32'h0000) begin failures++; $display("FAIL w16_add_acc got=%h want=0000", oOut); end
    drive(4'd4, 32'hBEEF); drive(4'd15, 32'h0);
    checks++;
    if (oOut !== 32'hBEEF || oIdx !== 32'hBEEF || oOv !== 1'b1) begin
      failures++; $display("FAIL w16_oeid got out=%h idx=%h ov=%b want beef/beef/1", oOut, oIdx, oOv);
    end
    drive(4'd1, 32'h0003); drive(4'd2, 32'h0005); drive(4'd13, 32'h0);
    checks++;
    if (oReady !== 1'b1 || oBusy !== 1'b0 || oFlags !== 4'b1100) begin
      failures++; $display("FAIL w16_mul_nop got ready=%b busy=%b flags=%b want 1/0/1100", oReady, oBusy, oFlags);
    end
    drive(4'd14, 32'h0);
    checks++;
    if (oOut !== 32'h0000) begin failures++; $display("FAIL w16_mul_nop_acc got=%h want=0000", oOut); end
    tbSel = 1'b0;
  endtask

  initial begin
    Rst = 1'b0;
    op8 = 4'd0; op16 = 4'd0;
    valid8 = 1'b0; valid16 = 1'b0;
    in8 = 8'h0; in16 = 16'h0;
    test_reset();
    test_add_oe();
    test_sub_cmpe();
    test_mul_stall();
    test_mul_reset();
    test_shift_logic();
    test_random();
    test_width16();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
